ctrl_sequencer: RTL and testbench

- Multi-cycle controller that generates the 8-bit `ctrl_bus` for the 4-bit datapath.
- Datapath `ctrl_bus` map: R-mux select [3], ALU op [2:0], shifter mode [5:4], Q load [6], R load [7].
- Accepts one packed instruction per valid/ready handshake and expands it into 1..2^REP_W datapath operations.
- Intermediate results accumulate in R; the final operation commits to Q.

---
 rtl/ctrl_sequencer.sv | 118 +++++++++++
 tb/tb_ctrl_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// Multi-cycle controller expanding packed instructions into datapath ctrl_bus ops.
// Optional retired-instruction counter enabled by CTRL_SEQ_RETIRE_CNT_EN.
module ctrl_sequencer #(
    parameter int          REP_W     = 2,
    parameter logic [7:0]  IDLE_CTRL = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REP_W+5:0] instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             abort,
    output logic [7:0]       ctrl_bus,
    output logic             busy,
    output logic             done,
    output logic [7:0]       retired_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        COMMIT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [REP_W+5:0] ir;
    logic [REP_W-1:0] cnt;
    logic             accept;
    logic [REP_W-1:0] ir_rep;
    logic [REP_W-1:0] in_rep;
    logic [1:0]       ir_shift;
    logic             ir_src;
    logic [2:0]       ir_op;
    logic             src_eff;

    assign ir_rep   = ir[REP_W+5:6];
    assign in_rep   = instr[REP_W+5:6];
    assign ir_shift = ir[5:4];
    assign ir_src   = ir[3];
    assign ir_op    = ir[2:0];

    assign instr_ready = (state == IDLE);
    assign accept      = instr_valid & instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ir    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                ir  <= instr;
                cnt <= in_rep;
            end else if (state == ITER) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nx = (in_rep != '0) ? ITER : COMMIT;
            end
            ITER: begin
                if (abort)
                    state_nx = IDLE;
                else if (cnt == REP_W'(1))
                    state_nx = COMMIT;
            end
            COMMIT: state_nx = abort ? IDLE : DONE;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Counter still equals rep only on the first operation of an instruction
    assign src_eff = (cnt == ir_rep) ? ir_src : 1'b1;

    always_comb begin
        ctrl_bus = IDLE_CTRL;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            ITER: begin
                ctrl_bus = {2'b10, ir_shift, src_eff, ir_op};
                busy     = 1'b1;
            end
            COMMIT: begin
                ctrl_bus = {2'b11, ir_shift, src_eff, ir_op};
                busy     = 1'b1;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

`ifdef CTRL_SEQ_RETIRE_CNT_EN
    logic [7:0] retired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retired_q <= 8'h00;
        else if (state == DONE)
            retired_q <= retired_q + 8'h01;
    end

    assign retired_cnt = retired_q;
`else
    assign retired_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed scoreboard bench for ctrl_sequencer: expected cycle items are
// queued when an instruction is driven and checked as the DUT steps.
module tb_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       abort;
    logic [7:0] ctrl_bus;
    logic       busy;
    logic       done;
    logic [7:0] retired_cnt;

    int         total = 0;
    int         bad = 0;
    logic [7:0] ret_model = 8'h00;
    // item = {ready, busy, done, ctrl_bus}
    logic [10:0] sb[$];

    always #5 clk = ~clk;

    ctrl_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .abort       (abort),
        .ctrl_bus    (ctrl_bus),
        .busy        (busy),
        .done        (done),
        .retired_cnt (retired_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected items for one instruction; ab = op index where abort lands
    task automatic push_seq(input logic [7:0] in, input int ab);
        int  rep;
        bit  aborted;
        logic s;
        logic ql;
        rep = int'(in[7:6]);
        aborted = 1'b0;
        for (int k = 0; k <= rep; k++) begin
            if (!aborted) begin
                s  = (k == 0) ? in[3] : 1'b1;
                ql = (k == rep);
                sb.push_back({3'b010, 1'b1, ql, in[5:4], s, in[2:0]});
                if (k == ab) aborted = 1'b1;
            end
        end
        if (!aborted) begin
            sb.push_back({3'b001, 8'h00});
`ifdef CTRL_SEQ_RETIRE_CNT_EN
            ret_model = ret_model + 8'h01;
`endif
        end
        sb.push_back({3'b100, 8'h00});
    endtask

    // Steps the DUT one cycle per queued item, starting just after accept
    task automatic drain(input string tag, input int abort_idx,
                         input int valid_off, input logic [7:0] swap);
        logic [10:0] e;
        int idx;
        idx = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            if (idx == 0) instr = swap;
            if (idx == valid_off) instr_valid = 1'b0;
            e = sb.pop_front();
            chk($sformatf("%s[%0d]", tag, idx),
                {21'd0, instr_ready, busy, done, ctrl_bus}, {21'd0, e});
            abort = (idx == abort_idx);
            idx++;
        end
        abort = 1'b0;
        chk({tag, ".retired"}, {24'd0, retired_cnt}, {24'd0, ret_model});
    endtask

    task automatic start(input logic [7:0] in);
        @(negedge clk);
        instr       = in;
        instr_valid = 1'b1;
    endtask

    initial begin
        rst         = 1'b1;
        instr       = 8'h00;
        instr_valid = 1'b0;
        abort       = 1'b0;
        #12;
        chk("reset.ctrl", {24'd0, ctrl_bus}, 32'h00);
        chk("reset.flags", {29'd0, instr_ready, busy, done}, 32'h4);
        chk("reset.retired", {24'd0, retired_cnt}, 32'h00);
        @(negedge clk);
        rst = 1'b0;

        // single operation
        start(8'h00);
        push_seq(8'h00, -1);
        drain("single", -1, 0, 8'h00);

        // repeated operation: A5 AD AD ED, done, ready 6 cycles later
        start(8'hE5);
        push_seq(8'hE5, -1);
        drain("repeat", -1, 0, 8'h00);

        // backpressure: 4B held valid throughout E5
        start(8'hE5);
        push_seq(8'hE5, -1);
        push_seq(8'h4B, -1);
        drain("backpr", -1, 6, 8'h4B);

        // abort in the 2nd ITER cycle
        start(8'hC2);
        push_seq(8'hC2, 1);
        drain("abort_iter", 1, 0, 8'h00);

        // abort in COMMIT: commit op still driven, no done
        start(8'h40);
        push_seq(8'h40, 1);
        drain("abort_commit", 1, 0, 8'h00);

        // abort in DONE is ignored
        start(8'h5E);
        push_seq(8'h5E, -1);
        drain("abort_done", 2, 0, 8'h00);

        // abort with valid in IDLE: instruction accepted
        start(8'h97);
        abort = 1'b1;
        push_seq(8'h97, -1);
        drain("abort_idle", -1, 0, 8'h00);

        // async reset mid-COMMIT
        start(8'h40);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("arst.pre", {24'd0, ctrl_bus}, 32'hC8);
        #2 rst = 1'b1;
        #1;
        chk("arst.ctrl", {24'd0, ctrl_bus}, 32'h00);
        chk("arst.flags", {29'd0, instr_ready, busy, done}, 32'h4);
        chk("arst.retired", {24'd0, retired_cnt}, 32'h00);
        ret_model = 8'h00;
        #1 rst = 1'b0;

`ifdef CTRL_SEQ_RETIRE_CNT_EN
        for (int n = 0; n < 257; n++) begin
            start(8'h00);
            push_seq(8'h00, -1);
            drain("wrap", -1, 0, 8'h00);
            if (n == 255)
                chk("wrap.zero", {24'd0, retired_cnt}, 32'h00);
        end
        chk("wrap.one", {24'd0, retired_cnt}, 32'h01);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
